// File: rtl/sos_stream_driver_if.sv
// Sample/result handshake bundle between upstream, the driver, the SOS and downstream.
interface sos_stream_driver_if #(
  parameter int unsigned DATA_W = 24
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;

  // Driver side.
  modport master (
    input  s_valid, s_data, r_valid, r_data,
    output s_ready, m_valid, m_data, o_valid, o_data
  );

  // Environment side: upstream source, SOS and downstream sink.
  modport slave (
    output s_valid, s_data, r_valid, r_data,
    input  s_ready, m_valid, m_data, o_valid, o_data
  );

endinterface

// File: rtl/sos_stream_driver.sv
// Buffers upstream samples and issues them to the SOS one at a time, waiting for each
// result (or a timeout) before issuing the next, so the SOS feedback state can settle.
module sos_stream_driver #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sos_stream_driver_if.master         bus,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        timeout_err,
  output logic                        stray_err,
  input  logic                        clr_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [7:0]  TimeoutVal = TIMEOUT[7:0];

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [7:0]        timer_q, timer_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              tout_q, tout_d;
  logic              stray_q, stray_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              push, pop;

  assign bus.s_ready = (count_q < CntW'(FIFO_DEPTH));
  assign push        = bus.s_valid & bus.s_ready;

  // Sample storage; contents need no reset since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.s_data;
    end
  end

  // Next-state for the issue/wait FSM, FIFO pointers and sticky flags.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    pop       = 1'b0;
    // Clears apply first so a same-cycle set below overrides them.
    tout_d    = clr_err ? 1'b0 : tout_q;
    stray_d   = clr_err ? 1'b0 : stray_q;

    case (state_q)
      StIdle: begin
        if (bus.r_valid) begin
          stray_d = 1'b1;
        end
        // Only the registered count is consulted, so a fresh push waits one cycle.
        if (count_q != '0) begin
          pop       = 1'b1;
          m_valid_d = 1'b1;
          m_data_d  = mem[rd_ptr_q];
          timer_d   = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (bus.r_valid) begin
          o_valid_d = 1'b1;
          o_data_d  = bus.r_data;
          state_d   = StIdle;
        end else if (timer_q == TimeoutVal) begin
          tout_d  = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; asynchronous reset drops any buffered or in-flight sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      tout_q    <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      tout_q    <= tout_d;
      stray_q   <= stray_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign busy        = (state_q == StWait);
  assign fifo_count  = count_q;
  assign timeout_err = tout_q;
  assign stray_err   = stray_q;

endmodule

// File: tb/tb_sos_stream_driver.sv
// Directed bench for sos_stream_driver: issue/response timing, burst buffering,
// timeout and its boundary, stray results and asynchronous reset.
module tb_sos_stream_driver;

  localparam int unsigned DataW = 24;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [3:0] fifo_count;
  logic       timeout_err;
  logic       stray_err;
  logic       clr_err;

  int         n_cmp = 0;
  int         n_err = 0;
  int         busy_cnt;
  logic       flag;
  logic [23:0] samp [9];

  sos_stream_driver_if #(.DATA_W(DataW)) bus ();

  sos_stream_driver #(
    .DATA_W    (DataW),
    .FIFO_DEPTH(Depth),
    .TIMEOUT   (63)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err),
    .stray_err  (stray_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.r_valid = 1'b0;
    bus.r_data  = '0;
    clr_err     = 1'b0;
    for (int k = 0; k < 9; k++) samp[k] = 24'h200000 + 24'(k * 4097);

    // Reset values.
    repeat (3) tick();
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_o_valid", 32'(bus.o_valid), 0);
    chk("rst_o_data", 32'(bus.o_data), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_errs", {30'd0, timeout_err, stray_err}, 0);
    rst_n = 1'b1;
    tick();

    // Single sample, 14-cycle SOS round trip.
    bus.s_valid = 1'b1;
    bus.s_data  = 24'h100000;
    tick();
    bus.s_valid = 1'b0;
    chk("single_count_after_push", 32'(fifo_count), 1);
    chk("single_no_same_cycle_issue", 32'(bus.m_valid), 0);
    tick();
    chk("single_m_valid", 32'(bus.m_valid), 1);
    chk("single_m_data", 32'(bus.m_data), 32'h100000);
    chk("single_count_after_pop", 32'(fifo_count), 0);
    busy_cnt = busy ? 1 : 0;
    flag = 1'b0;
    repeat (13) begin
      tick();
      if (busy) busy_cnt++;
      if (bus.m_valid !== 1'b0 || bus.o_valid !== 1'b0) flag = 1'b1;
    end
    chk("single_quiet_wait", 32'(flag), 0);
    bus.r_valid = 1'b1;
    bus.r_data  = 24'h0ABCDE;
    tick();
    bus.r_valid = 1'b0;
    chk("single_o_valid", 32'(bus.o_valid), 1);
    chk("single_o_data", 32'(bus.o_data), 32'h0ABCDE);
    chk("single_busy_low", 32'(busy), 0);
    chk("single_busy_cycles", 32'(busy_cnt), 14);
    tick();
    chk("single_o_pulse", 32'(bus.o_valid), 0);
    chk("single_no_reissue", 32'(bus.m_valid), 0);

    // Burst of nine into an eight-entry FIFO while the first sample is outstanding.
    for (int k = 0; k < 9; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = samp[k];
      chk("burst_s_ready", 32'(bus.s_ready), 1);
      tick();
    end
    chk("burst_full_count", 32'(fifo_count), 8);
    chk("burst_full_ready", 32'(bus.s_ready), 0);
    chk("burst_busy", 32'(busy), 1);
    bus.s_data = 24'hDEAD00;
    tick();
    bus.s_valid = 1'b0;
    chk("burst_full_no_push", 32'(fifo_count), 8);
    chk("burst_first_data", 32'(bus.m_data), 32'(samp[0]));
    for (int k = 0; k < 9; k++) begin
      repeat (2) tick();
      bus.r_valid = 1'b1;
      bus.r_data  = 24'h0A0000 + 24'(k);
      tick();
      bus.r_valid = 1'b0;
      chk("burst_o_valid", 32'(bus.o_valid), 1);
      chk("burst_o_data", 32'(bus.o_data), 32'h0A0000 + 32'(k));
      chk("burst_idle_gap", 32'(bus.m_valid), 0);
      if (k < 8) begin
        tick();
        chk("burst_issue", 32'(bus.m_valid), 1);
        chk("burst_order", 32'(bus.m_data), 32'(samp[k+1]));
        chk("burst_count", 32'(fifo_count), 32'(7 - k));
      end
    end
    tick();
    chk("burst_drained_m_valid", 32'(bus.m_valid), 0);
    chk("burst_drained_count", 32'(fifo_count), 0);

    // Timeout: first sample abandoned, queued second sample issued next cycle.
    bus.s_valid = 1'b1;
    bus.s_data  = 24'h333333;
    tick();
    bus.s_data  = 24'h444444;
    tick();
    bus.s_valid = 1'b0;
    chk("tmo_issue", 32'(bus.m_valid), 1);
    chk("tmo_issue_data", 32'(bus.m_data), 32'h333333);
    flag = 1'b0;
    repeat (63) begin
      tick();
      if (timeout_err !== 1'b0 || bus.o_valid !== 1'b0 || busy !== 1'b1) flag = 1'b1;
    end
    chk("tmo_not_early", 32'(flag), 0);
    tick();
    chk("tmo_err_set", 32'(timeout_err), 1);
    chk("tmo_no_o_valid", 32'(bus.o_valid), 0);
    chk("tmo_idle", 32'(busy), 0);
    tick();
    chk("tmo_next_issue", 32'(bus.m_valid), 1);
    chk("tmo_next_data", 32'(bus.m_data), 32'h444444);
    chk("tmo_err_sticky", 32'(timeout_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_err_cleared", 32'(timeout_err), 0);

    // Boundary race: result arrives on the cycle the timer equals TIMEOUT.
    repeat (62) tick();
    bus.r_valid = 1'b1;
    bus.r_data  = 24'h123456;
    tick();
    bus.r_valid = 1'b0;
    chk("race_o_valid", 32'(bus.o_valid), 1);
    chk("race_o_data", 32'(bus.o_data), 32'h123456);
    chk("race_no_timeout", 32'(timeout_err), 0);
    chk("race_idle", 32'(busy), 0);
    tick();

    // Stray result while idle.
    bus.r_valid = 1'b1;
    bus.r_data  = 24'h7FFFFF;
    tick();
    bus.r_valid = 1'b0;
    chk("stray_set", 32'(stray_err), 1);
    chk("stray_no_o_valid", 32'(bus.o_valid), 0);
    chk("stray_o_data_kept", 32'(bus.o_data), 32'h123456);
    chk("stray_count", 32'(fifo_count), 0);
    clr_err     = 1'b1;
    bus.r_valid = 1'b1;
    tick();
    bus.r_valid = 1'b0;
    chk("stray_set_wins", 32'(stray_err), 1);
    tick();
    clr_err = 1'b0;
    chk("stray_cleared", 32'(stray_err), 0);

    // Asynchronous reset mid-WAIT with three samples queued.
    for (int k = 0; k < 4; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = samp[k];
      tick();
    end
    bus.s_valid = 1'b0;
    chk("arst_pre_count", 32'(fifo_count), 3);
    chk("arst_pre_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_s_ready", 32'(bus.s_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_m_valid", 32'(bus.m_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("arst_buffer_lost", 32'(bus.m_valid), 0);
    bus.r_valid = 1'b1;
    bus.r_data  = 24'h555555;
    tick();
    bus.r_valid = 1'b0;
    chk("arst_late_stray", 32'(stray_err), 1);
    chk("arst_late_no_o_valid", 32'(bus.o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
